// File: rtl/tile_writer.sv
// Tile colour writer: read-modify-write of a 2-bit tile field in the shared VRAM,
// with an optional whole-screen fill compiled in by TILE_WRITER_FILL_EN.
module tile_writer #(
    parameter int TILES_H = 28,
    parameter int TILES_V = 18,
    localparam int TILES_TOTAL = TILES_H * TILES_V,
    localparam int VRAM_SIZE   = (TILES_TOTAL + 3) / 4,
    localparam int AW          = $clog2(VRAM_SIZE),
    localparam int TW          = $clog2(TILES_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [TW-1:0] cmd_tile,
    input  logic [1:0]    cmd_color,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] vram_addr,
    output logic [7:0]    vram_wdata,
    output logic          vram_wenable,
    input  logic [7:0]    vram_rdata
);

    localparam logic [TW-1:0] LAST_TILE = TW'(TILES_TOTAL - 1);

`ifdef TILE_WRITER_FILL_EN
    localparam logic [AW-1:0] LAST_ADDR = AW'(VRAM_SIZE - 1);
    typedef enum logic [1:0] {IDLE, READ, WRITE, FILL} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
`endif

    state_t        state_q, state_d;
    logic          op_q, op_d;
    logic [TW-1:0] tile_q, tile_d;
    logic [1:0]    color_q, color_d;
    logic [7:0]    rdata_q, rdata_d;
`ifdef TILE_WRITER_FILL_EN
    logic [AW-1:0] cnt_q, cnt_d;
`endif

    // A SET only writes when it is a SET and the tile exists; anything else ends in READ.
    logic          set_ok;
    logic [AW-1:0] tile_addr;
    logic [2:0]    shift;
    logic [7:0]    field_mask;
    logic [7:0]    merged;

    assign set_ok     = !op_q && (tile_q <= LAST_TILE);
    assign tile_addr  = AW'(tile_q >> 2);
    assign shift      = {tile_q[1:0], 1'b0};
    assign field_mask = 8'h03 << shift;
    assign merged     = (rdata_q & ~field_mask) | ({6'b0, color_q} << shift);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tile_d  = tile_q;
        color_d = color_q;
        rdata_d = rdata_q;
`ifdef TILE_WRITER_FILL_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    tile_d  = cmd_tile;
                    color_d = cmd_color;
`ifdef TILE_WRITER_FILL_EN
                    if (cmd_op) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end else begin
                        state_d = READ;
                    end
`else
                    state_d = READ;
`endif
                end
            end
            READ: begin
                rdata_d = vram_rdata;
                state_d = set_ok ? WRITE : IDLE;
            end
            WRITE: state_d = IDLE;
`ifdef TILE_WRITER_FILL_EN
            FILL: begin
                // Hold at the last address rather than wrapping.
                if (cnt_q == LAST_ADDR) state_d = IDLE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the registered state only, so no input reaches an output combinationally.
    always_comb begin
        cmd_ready    = (state_q == IDLE);
        done         = 1'b0;
        err          = 1'b0;
        vram_wenable = 1'b0;
        vram_addr    = '0;
        vram_wdata   = 8'h00;
        case (state_q)
            READ: begin
                vram_addr = tile_addr;
                if (!set_ok) begin
                    done = 1'b1;
                    err  = 1'b1;
                end
            end
            WRITE: begin
                vram_addr    = tile_addr;
                vram_wenable = 1'b1;
                vram_wdata   = merged;
                done         = 1'b1;
            end
`ifdef TILE_WRITER_FILL_EN
            FILL: begin
                vram_addr    = cnt_q;
                vram_wenable = 1'b1;
                vram_wdata   = {4{color_q}};
                done         = (cnt_q == LAST_ADDR);
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            tile_q  <= '0;
            color_q <= 2'b00;
            rdata_q <= 8'h00;
`ifdef TILE_WRITER_FILL_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tile_q  <= tile_d;
            color_q <= color_d;
            rdata_q <= rdata_d;
`ifdef TILE_WRITER_FILL_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tile_writer.sv
// Directed bench for tile_writer with a behavioural VRAM; fill tests only when
// TILE_WRITER_FILL_EN is defined, otherwise the disabled-op behaviour is checked.
module tb_tile_writer;

    localparam int TW = 9;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [TW-1:0] cmd_tile;
    logic [1:0]    cmd_color;
    logic          done;
    logic          err;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_wdata;
    logic          vram_wenable;
    logic [7:0]    vram_rdata;

    logic [7:0]    mem [0:127];
    int            wr_count;
    logic          tb_clr;
    logic          tb_we;
    logic [6:0]    tb_addr;
    logic [7:0]    tb_data;

    int checks = 0;
    int errors = 0;
    int base;

    always #5 clk = ~clk;

    tile_writer #(.TILES_H(28), .TILES_V(18)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_tile     (cmd_tile),
        .cmd_color    (cmd_color),
        .done         (done),
        .err          (err),
        .vram_addr    (vram_addr),
        .vram_wdata   (vram_wdata),
        .vram_wenable (vram_wenable),
        .vram_rdata   (vram_rdata)
    );

    // VRAM stand-in: combinational read, clocked write, plus a bench preload port.
    assign vram_rdata = mem[vram_addr];

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
            wr_count <= 0;
        end else if (vram_wenable) begin
            mem[vram_addr] <= vram_wdata;
            wr_count <= wr_count + 1;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Offers a command in cycle N and returns at the start of cycle N+1 (not yet settled).
    task automatic send(input logic op, input logic [TW-1:0] tile, input logic [1:0] color);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_tile = tile; cmd_color = color;
        #1 check("ready_at_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_tile = '0; cmd_color = 2'b00;
        tb_clr = 1'b1; tb_we = 1'b0; tb_addr = '0; tb_data = 8'h00;
        repeat (3) @(negedge clk);
        tb_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_we", vram_wenable, 0);
        check("rst_addr", vram_addr, 0);
        check("rst_wdata", vram_wdata, 0);

        // Tile 21 -> byte 5 bits [3:2].
        base = wr_count;
        send(1'b0, 9'd21, 2'd3);
        #1;
        check("t21_read_addr", vram_addr, 5);
        check("t21_read_we", vram_wenable, 0);
        check("t21_read_done", done, 0);
        check("t21_read_ready", cmd_ready, 0);
        @(negedge clk); #1;
        check("t21_wr_addr", vram_addr, 5);
        check("t21_wr_we", vram_wenable, 1);
        check("t21_wr_data", vram_wdata, 8'h0C);
        check("t21_wr_done", done, 1);
        check("t21_wr_err", err, 0);
        @(negedge clk); #1;
        check("t21_ready_after", cmd_ready, 1);
        check("t21_done_after", done, 0);
        check("t21_mem5", mem[5], 8'h0C);
        check("t21_wr_count", wr_count - base, 1);

        // Tile 0 on a full byte; neighbour byte must survive.
        poke(7'd0, 8'hFF);
        poke(7'd1, 8'h5A);
        base = wr_count;
        send(1'b0, 9'd0, 2'd1);
        @(negedge clk); #1;
        check("t0_wr_data", vram_wdata, 8'hFD);
        check("t0_wr_addr", vram_addr, 0);
        @(negedge clk); #1;
        check("t0_mem0", mem[0], 8'hFD);
        check("t0_mem1", mem[1], 8'h5A);
        check("t0_mem5", mem[5], 8'h0C);
        check("t0_wr_count", wr_count - base, 1);

        // Tile 23: top field of byte 5, keeps the earlier tile 21 colour.
        send(1'b0, 9'd23, 2'd2);
        @(negedge clk); #1;
        check("t23_wr_data", vram_wdata, 8'h8C);
        @(negedge clk); #1;
        check("t23_mem5", mem[5], 8'h8C);

        // Fields latched at acceptance; later changes on the bus are ignored.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_tile = 9'd6; cmd_color = 2'd3;
        @(negedge clk);
        cmd_tile = 9'd7; cmd_color = 2'd0;
        #1 check("busy_ready", cmd_ready, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        check("t6_wr_addr", vram_addr, 1);
        check("t6_wr_data", vram_wdata, 8'h7A);
        @(negedge clk); #1;
        check("t6_mem1", mem[1], 8'h7A);
        check("t6_idle_we", vram_wenable, 0);

        // Out-of-range tiles: first index past the end, and the largest encodable.
        base = wr_count;
        send(1'b0, 9'd504, 2'd2);
        #1;
        check("t504_done", done, 1);
        check("t504_err", err, 1);
        check("t504_we", vram_wenable, 0);
        @(negedge clk); #1;
        check("t504_ready", cmd_ready, 1);
        check("t504_done_after", done, 0);
        check("t504_err_after", err, 0);
        send(1'b0, 9'd511, 2'd1);
        #1;
        check("t511_err", err, 1);
        check("t511_we", vram_wenable, 0);
        @(negedge clk); #1;
        check("oor_wr_count", wr_count - base, 0);

        // Tile 503 is the last valid one: byte 125 bits [7:6].
        send(1'b0, 9'd503, 2'd1);
        #1 check("t503_err", err, 0);
        @(negedge clk); #1;
        check("t503_wr_addr", vram_addr, 125);
        check("t503_wr_data", vram_wdata, 8'h40);
        @(negedge clk); #1;
        check("t503_mem125", mem[125], 8'h40);

        // Reset during READ aborts the SET with no write.
        base = wr_count;
        send(1'b0, 9'd8, 2'd3);
        rst = 1'b1;
        #1;
        check("rstset_ready", cmd_ready, 1);
        check("rstset_we", vram_wenable, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("rstset_wr_count", wr_count - base, 0);
        check("rstset_mem2", mem[2], 8'h00);

`ifdef TILE_WRITER_FILL_EN
        base = wr_count;
        send(1'b1, 9'd0, 2'd2);
        for (int i = 0; i < 126; i++) begin
            #1;
            check("fill_addr", vram_addr, i);
            check("fill_data", vram_wdata, 8'hAA);
            check("fill_we", vram_wenable, 1);
            check("fill_ready", cmd_ready, 0);
            check("fill_done", done, (i == 125) ? 1 : 0);
            @(negedge clk);
        end
        #1;
        check("fill_end_ready", cmd_ready, 1);
        check("fill_end_we", vram_wenable, 0);
        check("fill_wr_count", wr_count - base, 126);
        check("fill_mem0", mem[0], 8'hAA);
        check("fill_mem125", mem[125], 8'hAA);

        // Reset while the 40th write (address 39) is on the bus.
        send(1'b1, 9'd0, 2'd1);
        for (int i = 0; i < 39; i++) @(negedge clk);
        #1 check("rstfill_addr39", vram_addr, 39);
        rst = 1'b1;
        #1;
        check("rstfill_we", vram_wenable, 0);
        check("rstfill_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("rstfill_we_after", vram_wenable, 0);
        check("rstfill_mem0", mem[0], 8'h55);
        check("rstfill_mem38", mem[38], 8'h55);
        check("rstfill_mem39", mem[39], 8'hAA);
        check("rstfill_mem125", mem[125], 8'hAA);
`else
        base = wr_count;
        send(1'b1, 9'd3, 2'd2);
        #1;
        check("nofill_done", done, 1);
        check("nofill_err", err, 1);
        check("nofill_we", vram_wenable, 0);
        @(negedge clk); #1;
        check("nofill_ready", cmd_ready, 1);
        check("nofill_done_after", done, 0);
        check("nofill_wr_count", wr_count - base, 0);
        check("nofill_mem0", mem[0], 8'hFD);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
